// File: rtl/stage_sequencer.sv
// stage_sequencer: walks fetch -> decode_execute -> memory_writeback -> retire with start/done handshakes.
// Latency: every output is registered; minimum instruction is 4 cycles, with one state per cycle when each done arrives with its start pulse.
// Backpressure: a stage is held until its done arrives. After TIMEOUT+1 cycles without done, the sequencer enters ERR; only rst leaves HALT or ERR.
//
// Ports:
//   clk, rst (sync, active high)  | run: level enable for starting instructions
//   fetch_done/de_done/mw_done    | stage completion inputs, honoured only in the matching state
//   halt_req                      | qualified by de_done in DE
//   *_start, pc_we                | one-cycle pulses
//   busy/halted/timeout_err/stage | state decode
//   cycles/instret                | wrapping counters
module stage_sequencer #(
    parameter int TIMEOUT   = 255,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 fetch_done,
    input  logic                 de_done,
    input  logic                 halt_req,
    input  logic                 mw_done,
    output logic                 fetch_start,
    output logic                 de_start,
    output logic                 mw_start,
    output logic                 pc_we,
    output logic                 busy,
    output logic                 halted,
    output logic                 timeout_err,
    output logic [2:0]           stage,
    output logic [CNT_WIDTH-1:0] cycles,
    output logic [CNT_WIDTH-1:0] instret
);

    // The watchdog is at least 8 bits wide and always wide enough to hold TIMEOUT.
    localparam int WD_RAW = $clog2(TIMEOUT + 1);
    localparam int WD_W   = (WD_RAW < 8) ? 8 : WD_RAW;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_IF     = 3'd1,
        S_DE     = 3'd2,
        S_MW     = 3'd3,
        S_RETIRE = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  fetch_start_q, fetch_start_d;
    logic                  de_start_q, de_start_d;
    logic                  mw_start_q, mw_start_d;
    logic                  pc_we_q, pc_we_d;
    logic                  busy_q, busy_d;
    logic                  halted_q, halted_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [CNT_WIDTH-1:0]  cycles_q, cycles_d;
    logic [CNT_WIDTH-1:0]  instret_q, instret_d;

    logic                  in_stage;
    logic                  cur_done;
    logic                  entering;

    // Next-state logic. When done and the watchdog limit coincide, done is
    // tested first, so the normal transition is taken.
    always_comb begin
        state_d  = state_q;
        in_stage = 1'b0;
        cur_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_IF;
            end
            S_IF: begin
                in_stage = 1'b1;
                cur_done = fetch_done;
                if (fetch_done)            state_d = S_DE;
                else if (wd_q == WD_LIMIT) state_d = S_ERR;
            end
            S_DE: begin
                in_stage = 1'b1;
                cur_done = de_done;
                if (de_done)               state_d = halt_req ? S_HALT : S_MW;
                else if (wd_q == WD_LIMIT) state_d = S_ERR;
            end
            S_MW: begin
                in_stage = 1'b1;
                cur_done = mw_done;
                if (mw_done)               state_d = S_RETIRE;
                else if (wd_q == WD_LIMIT) state_d = S_ERR;
            end
            S_RETIRE: begin
                state_d = run ? S_IF : S_IDLE;
            end
            default: begin
                // HALT and ERR are terminal until reset.
                state_d = state_q;
            end
        endcase
    end

    // Watchdog, registered outputs and counters.
    always_comb begin
        entering = (state_d != state_q);

        wd_d = wd_q;
        if (entering) begin
            wd_d = '0;
        end else if (in_stage && !cur_done) begin
            // Staying in the state implies wd_q < WD_LIMIT, so this cannot overflow.
            wd_d = wd_q + WD_W'(1);
        end

        // Pulse and decode flops are loaded from the next state, so they
        // line up with the state register.
        fetch_start_d = entering && (state_d == S_IF);
        de_start_d    = entering && (state_d == S_DE);
        mw_start_d    = entering && (state_d == S_MW);
        pc_we_d       = (state_d == S_RETIRE);
        busy_d        = (state_d == S_IF) || (state_d == S_DE) ||
                        (state_d == S_MW) || (state_d == S_RETIRE);
        halted_d      = (state_d == S_HALT);
        timeout_err_d = (state_d == S_ERR);

        // Each counter accounts for the cycle that is just ending.
        cycles_d  = cycles_q;
        if (busy_q) cycles_d = cycles_q + CNT_WIDTH'(1);
        instret_d = instret_q;
        if (state_q == S_RETIRE) instret_d = instret_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wd_q          <= '0;
            fetch_start_q <= 1'b0;
            de_start_q    <= 1'b0;
            mw_start_q    <= 1'b0;
            pc_we_q       <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            cycles_q      <= '0;
            instret_q     <= '0;
        end else begin
            state_q       <= state_d;
            wd_q          <= wd_d;
            fetch_start_q <= fetch_start_d;
            de_start_q    <= de_start_d;
            mw_start_q    <= mw_start_d;
            pc_we_q       <= pc_we_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
            timeout_err_q <= timeout_err_d;
            cycles_q      <= cycles_d;
            instret_q     <= instret_d;
        end
    end

    assign fetch_start = fetch_start_q;
    assign de_start    = de_start_q;
    assign mw_start    = mw_start_q;
    assign pc_we       = pc_we_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign timeout_err = timeout_err_q;
    assign stage       = state_q;
    assign cycles      = cycles_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Testbench for stage_sequencer: directed scenarios plus randomized traffic.
// Each cycle the DUT outputs are compared with a reference model that tracks
// the current stage and how long it has been occupied.
module tb_stage_sequencer;

    localparam int TO = 6;
    localparam int CW = 8;
    localparam int unsigned CMASK = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          fetch_done;
    logic          de_done;
    logic          halt_req;
    logic          mw_done;
    logic          fetch_start;
    logic          de_start;
    logic          mw_start;
    logic          pc_we;
    logic          busy;
    logic          halted;
    logic          timeout_err;
    logic [2:0]    stage;
    logic [CW-1:0] cycles;
    logic [CW-1:0] instret;

    always #5 clk = ~clk;

    stage_sequencer #(.TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .fetch_done  (fetch_done),
        .de_done     (de_done),
        .halt_req    (halt_req),
        .mw_done     (mw_done),
        .fetch_start (fetch_start),
        .de_start    (de_start),
        .mw_start    (mw_start),
        .pc_we       (pc_we),
        .busy        (busy),
        .halted      (halted),
        .timeout_err (timeout_err),
        .stage       (stage),
        .cycles      (cycles),
        .instret     (instret)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model. Stage numbering follows the interface encoding:
    // 0 idle, 1 fetch, 2 decode/execute, 3 memory/writeback, 4 retire,
    // 5 halt, 6 error. m_age is the number of cycles spent in the
    // current stage, counting the current cycle.
    int          m_stage = 0;
    int          m_age   = 1;
    int unsigned m_cycles  = 0;
    int unsigned m_instret = 0;

    task automatic model_step();
        int nxt;
        if (rst) begin
            m_stage   = 0;
            m_age     = 1;
            m_cycles  = 0;
            m_instret = 0;
            return;
        end
        if (m_stage >= 1 && m_stage <= 4) m_cycles  = (m_cycles + 1) & CMASK;
        if (m_stage == 4)                 m_instret = (m_instret + 1) & CMASK;
        nxt = m_stage;
        case (m_stage)
            0: if (run) nxt = 1;
            1: if (fetch_done) nxt = 2; else if (m_age > TO) nxt = 6;
            2: if (de_done) nxt = halt_req ? 5 : 3; else if (m_age > TO) nxt = 6;
            3: if (mw_done) nxt = 4; else if (m_age > TO) nxt = 6;
            4: nxt = run ? 1 : 0;
            default: nxt = m_stage;
        endcase
        m_age   = (nxt == m_stage) ? m_age + 1 : 1;
        m_stage = nxt;
    endtask

    task automatic compare_all();
        check_eq("stage",       32'(stage),       32'(m_stage));
        check_eq("fetch_start", 32'(fetch_start), 32'(m_stage == 1 && m_age == 1));
        check_eq("de_start",    32'(de_start),    32'(m_stage == 2 && m_age == 1));
        check_eq("mw_start",    32'(mw_start),    32'(m_stage == 3 && m_age == 1));
        check_eq("pc_we",       32'(pc_we),       32'(m_stage == 4));
        check_eq("busy",        32'(busy),        32'(m_stage >= 1 && m_stage <= 4));
        check_eq("halted",      32'(halted),      32'(m_stage == 5));
        check_eq("timeout_err", 32'(timeout_err), 32'(m_stage == 6));
        check_eq("cycles",      32'(cycles),      m_cycles);
        check_eq("instret",     32'(instret),     m_instret);
    endtask

    // Inputs change only 1 time unit after a rising edge, so they are
    // stable when both the DUT and the model sample them.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_in(input logic r, input logic fd, input logic dd, input logic hr, input logic md);
        run = r; fetch_done = fd; de_done = dd; halt_req = hr; mw_done = md;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin
        int n, starts, pulses, snap;
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        tick();
        do_reset();

        // Every done tied high: stage sequence 1,2,3,4 repeating.
        set_in(1, 1, 1, 0, 1);
        pulses = 0;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (i < 12) check_eq("seq_stage", 32'(stage), 32'((i % 4) + 1));
            if (pc_we) pulses++;
        end
        check_eq("seq_pc_we_pulses", pulses, 3);
        check_eq("seq_instret3", 32'(instret), 3);
        check_eq("seq_cycles12", 32'(cycles), 12);

        // mw_done arrives 5 cycles after mw_start.
        do_reset();
        set_in(1, 1, 1, 0, 0);
        tick();
        run = 1'b0;
        n = 0;
        while (stage != 3'd3 && n < 10) begin tick(); n++; end
        n = 0; starts = 0;
        while (stage == 3'd3 && n < 20) begin
            n++;
            if (mw_start) starts++;
            mw_done = (n == 6);
            tick();
        end
        check_eq("mw_len", n, 6);
        check_eq("mw_start_once", starts, 1);
        mw_done = 1'b0;
        n = 0;
        while (stage != 3'd0 && n < 10) begin tick(); n++; end
        check_eq("instr_len9", 32'(cycles), 9);

        // Halt requested together with de_done.
        do_reset();
        set_in(1, 1, 1, 1, 1);
        starts = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (mw_start) starts++;
        end
        check_eq("halt_stage", 32'(stage), 5);
        check_eq("halt_flag", 32'(halted), 1);
        check_eq("halt_no_mw", starts, 0);
        check_eq("halt_instret", 32'(instret), 0);

        // Watchdog in fetch: fetch_done never comes.
        do_reset();
        set_in(1, 0, 1, 0, 1);
        tick();
        n = 0;
        while (stage == 3'd1 && n < 40) begin n++; tick(); end
        check_eq("wd_if_len", n, TO + 1);
        check_eq("wd_err_stage", 32'(stage), 6);
        check_eq("wd_err_flag", 32'(timeout_err), 1);
        for (int i = 0; i < 3; i++) tick();
        check_eq("wd_err_sticky", 32'(stage), 6);

        // fetch_done in the last allowed cycle takes the normal path.
        do_reset();
        set_in(1, 0, 0, 0, 0);
        tick();
        for (int i = 1; i <= TO + 1; i++) begin
            fetch_done = (i == TO + 1);
            tick();
        end
        check_eq("wd_done_wins", 32'(stage), 2);

        // run dropped during decode/execute.
        do_reset();
        set_in(1, 1, 0, 0, 1);
        tick();
        tick();
        run = 1'b0;
        tick();
        de_done = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pc_we) pulses++;
        end
        check_eq("drop_pc_we_once", pulses, 1);
        check_eq("drop_idle", 32'(stage), 0);
        snap = int'(cycles);
        for (int i = 0; i < 3; i++) tick();
        check_eq("drop_cycles_frozen", 32'(cycles), 32'(snap));
        run = 1'b1;
        tick();
        check_eq("drop_restart_if", 32'(stage), 1);

        // Reset in the middle of memory/writeback.
        do_reset();
        set_in(1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        check_eq("mid_mw_stage", 32'(stage), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_mw_rst_stage", 32'(stage), 0);
        check_eq("mid_mw_rst_cycles", 32'(cycles), 0);
        set_in(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) tick();
        check_eq("late_mw_done_ignored", 32'(stage), 0);

        // Randomized traffic; long enough for the counters to wrap.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (stage == 3'd5 || stage == 3'd6) rst = ($urandom_range(3) == 0);
            else                                 rst = ($urandom_range(127) == 0);
            run        = ($urandom_range(9) < 8);
            fetch_done = ($urandom_range(9) < 6);
            de_done    = ($urandom_range(9) < 6);
            halt_req   = ($urandom_range(31) == 0);
            mw_done    = ($urandom_range(9) < 6);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Multi-cycle instruction sequencer for the TinyRisc-V core. It drives the fetch, decode_execute and memory_writeback stages one after another using start/done handshakes, and advances the PC when an instruction retires. It also counts cycles and retired instructions, detects a stage that never completes (watchdog) and stops permanently on a halt request. It sits beside the datapath in the core top level and is the consumer of each stage's `done` output.

## Interface
- `TIMEOUT`, default 255: maximum number of cycles a stage may spend in its state without `done` before the sequencer errors.
- `CNT_WIDTH`, default 32: width of the `cycles` and `instret` counters.

- `clk` input 1: core clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `run` input 1: level enable. Starts a new instruction when the sequencer is idle and the previous one has retired.
- `fetch_done` input 1: fetch stage has completed.
- `de_done` input 1: decode_execute stage has completed.
- `halt_req` input 1: decoded instruction is ECALL/EBREAK/illegal. Only meaningful together with `de_done`.
- `mw_done` input 1: memory_writeback `done`.
- `fetch_start` output 1: one-cycle start pulse to fetch.
- `de_start` output 1: one-cycle start pulse to decode_execute.
- `mw_start` output 1: one-cycle start pulse to memory_writeback.
- `pc_we` output 1: PC register write enable. A one-cycle pulse at retirement.
- `busy` output 1: high in IF, DE, MW and RETIRE.
- `halted` output 1: high in HALT.
- `timeout_err` output 1: high in ERR.
- `stage` output 3: current state encoding.
- `cycles` output CNT_WIDTH: count of busy cycles.
- `instret` output CNT_WIDTH: count of retired instructions.

## Operation
- States and `stage` encodings: IDLE=0, IF=1, DE=2, MW=3, RETIRE=4, HALT=5, ERR=6.
- IDLE: go to IF when `run`=1, otherwise stay in IDLE.
- IF: go to DE when `fetch_done`=1.
- DE: when `de_done`=1, go to HALT if `halt_req`=1, otherwise go to MW.
- MW: go to RETIRE when `mw_done`=1.
- RETIRE: lasts exactly one cycle. `pc_we`=1 and `instret` increments. Next state is IF if `run`=1, otherwise IDLE.
- HALT and ERR are terminal. Only `rst` leaves them.
- Start pulses: each `*_start` is high only in the first cycle after entering the matching state.
- A `done` is sampled in every cycle of its state, including the start-pulse cycle.
- Any `done` asserted while not in its own state is ignored.
- `halt_req` is ignored except in DE together with `de_done`.
- Watchdog counter (8+ bits, sized to hold `TIMEOUT`):
  - clears on every state entry;
  - increments each cycle in IF, DE or MW while the relevant `done` is low;
  - when it reaches `TIMEOUT` with `done` still low, the next state is ERR.
- Watchdog and `done` in the same cycle: `done` wins and the normal transition is taken.
- `cycles` increments in every cycle where `busy`=1.
- Both counters wrap modulo 2^CNT_WIDTH and are never saturated.
- `run` deasserted mid-instruction: the current instruction completes through RETIRE, then the sequencer goes to IDLE. It never aborts a stage.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE, `stage`=0;
  - all pulses 0;
  - `busy`, `halted`, `timeout_err` all 0;
  - `cycles`=0, `instret`=0;
  - watchdog counter 0.
- `rst` takes priority over every transition, from any state, including mid-stage.
- Minimum instruction length is 4 cycles (IF, DE, MW, RETIRE), reached when every `done` comes in the start-pulse cycle.
- With `run` held high, back-to-back instructions have no IDLE cycle: RETIRE is followed directly by IF.
- From IDLE with `run`=1 at edge N, `stage`=1 and `fetch_start`=1 after edge N.
- ERR is entered after exactly `TIMEOUT`+1 cycles in a stage without `done`.

## Test plan
- Reset, then `run`=1 with each `done` tied high:
  - `stage` cycles 1,2,3,4 repeatedly;
  - `pc_we` pulses every 4th cycle;
  - after 3 instructions, `instret`=3 and `cycles`=12.
- `mw_done` delayed 5 cycles after `mw_start`:
  - MW lasts 6 cycles;
  - `mw_start` is high for 1 cycle only;
  - the instruction takes 9 cycles.
- `halt_req`=1 with `de_done` in DE:
  - `stage`=5 next, `halted`=1, MW is never started, `instret` unchanged;
  - stays halted with `run`=1 until `rst`.
- `TIMEOUT`=4, `fetch_done` held low:
  - ERR is entered after 5 cycles in IF, with `timeout_err`=1;
  - repeat with `fetch_done` asserted in the 5th cycle: DE is entered instead.
- `run` dropped during DE:
  - the instruction completes and `pc_we` pulses once;
  - then `stage`=0 and `cycles` freezes;
  - raising `run` again restarts at IF.
- `rst` asserted mid-MW:
  - all outputs return to reset values on the next edge;
  - `mw_done` arriving afterwards is ignored.
